// File: rtl/chess_pkg.sv
// Shared constants for the board evaluator: piece code ranges, material values,
// slave register offsets and the evaluator FSM state type.
package chess_pkg;

    localparam logic [8:0] EMPTY        = 9'd0;
    localparam logic [8:0] WPAWN0       = 9'd1;
    localparam logic [8:0] WPAWN_LAST   = 9'd8;
    localparam logic [8:0] WROOK0       = 9'd9;
    localparam logic [8:0] WROOK_LAST   = 9'd18;
    localparam logic [8:0] WKNIGHT0     = 9'd19;
    localparam logic [8:0] WKNIGHT_LAST = 9'd28;
    localparam logic [8:0] WBISHOP0     = 9'd29;
    localparam logic [8:0] WBISHOP_LAST = 9'd38;
    localparam logic [8:0] WQUEEN0      = 9'd39;
    localparam logic [8:0] WQUEEN_LAST  = 9'd47;
    localparam logic [8:0] WKING        = 9'd48;

    localparam logic signed [31:0] PAWN_VAL   = 32'sd100;
    localparam logic signed [31:0] ROOK_VAL   = 32'sd500;
    localparam logic signed [31:0] KNIGHT_VAL = 32'sd320;
    localparam logic signed [31:0] BISHOP_VAL = 32'sd330;
    localparam logic signed [31:0] QUEEN_VAL  = 32'sd900;
    localparam logic signed [31:0] KING_VAL   = 32'sd20000;

    localparam logic [3:0] REG_CTRL       = 4'd0;
    localparam logic [3:0] REG_SRC        = 4'd1;
    localparam logic [3:0] REG_DST        = 4'd2;
    localparam logic [3:0] REG_COUNT      = 4'd3;
    localparam logic [3:0] REG_COLOUR     = 4'd4;
    localparam logic [3:0] REG_BEST_IDX   = 4'd5;
    localparam logic [3:0] REG_BEST_SCORE = 4'd6;

    localparam logic [5:0]         LAST_SQ        = 6'd63;
    localparam logic [31:0]        BEST_IDX_RST   = 32'hFFFF_FFFF;
    localparam logic signed [31:0] BEST_SCORE_RST = 32'sh8000_0000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_ACC     = 3'd3,
        S_WR_REQ  = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Nine bits so that -128 maps to +128 instead of wrapping back to -128.
    function automatic logic [8:0] code_mag(input logic [7:0] code);
        return code[7] ? (9'd0 - {1'b1, code}) : {1'b0, code};
    endfunction

endpackage

// File: rtl/piece_value.sv
// Maps a signed square code to its signed material value; codes outside the
// known piece ranges (empty, >48, -128) are worth nothing.
module piece_value
    import chess_pkg::*;
(
    input  logic signed [7:0]  i_code,
    output logic signed [31:0] o_value
);

    logic [8:0]         w_mag;
    logic signed [31:0] w_abs;

    always_comb begin
        w_mag = code_mag(i_code);
        w_abs = '0;
        if (w_mag >= WPAWN0 && w_mag <= WPAWN_LAST) begin
            w_abs = PAWN_VAL;
        end else if (w_mag >= WROOK0 && w_mag <= WROOK_LAST) begin
            w_abs = ROOK_VAL;
        end else if (w_mag >= WKNIGHT0 && w_mag <= WKNIGHT_LAST) begin
            w_abs = KNIGHT_VAL;
        end else if (w_mag >= WBISHOP0 && w_mag <= WBISHOP_LAST) begin
            w_abs = BISHOP_VAL;
        end else if (w_mag >= WQUEEN0 && w_mag <= WQUEEN_LAST) begin
            w_abs = QUEEN_VAL;
        end else if (w_mag == WKING) begin
            w_abs = KING_VAL;
        end
        o_value = i_code[7] ? -w_abs : w_abs;
    end

endmodule

// File: rtl/board_eval.sv
// Avalon-MM material evaluator: reads candidate boards from SDRAM, writes one
// score word per board and keeps the index/score of the best board seen.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start after reset
// S_RD_REQ  | read request for square sq of board k, held through stalls
// S_RD_WAIT | single outstanding read, waiting for readdatavalid
// S_ACC     | add the captured square's value into the accumulator
// S_WR_REQ  | write board k's score, held through stalls; update best
// S_NEXT    | step to the next board or finish
// S_DONE    | run complete, done flag set, a new start is accepted
module board_eval
    import chess_pkg::*;
#(
    parameter int COUNT_W      = 8,
    parameter int BOARD_STRIDE = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    localparam logic [31:0] STRIDE = 32'(BOARD_STRIDE);

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_colour;
    logic                 r_done;
    logic [COUNT_W-1:0]   r_k;
    logic [5:0]           r_sq;
    logic signed [7:0]    r_code;
    logic signed [31:0]   r_acc;
    logic [31:0]          r_best_idx;
    logic signed [31:0]   r_best_score;

    logic                 w_busy;
    logic                 w_start;
    logic                 w_cfg_we;
    logic                 w_last_board;
    logic                 w_better;
    logic [31:0]          w_k_ext;
    logic [31:0]          w_rd_addr;
    logic [31:0]          w_wr_addr;
    logic signed [31:0]   w_value;
    logic signed [31:0]   w_score;
    logic                 w_unused;

    piece_value u_piece_value (
        .i_code  (r_code),
        .o_value (w_value)
    );

    assign w_unused     = ^master_readdata[31:8];
    assign w_busy       = !(r_state == S_IDLE || r_state == S_DONE);
    assign w_cfg_we     = slave_write && !w_busy;
    assign w_start      = w_cfg_we && (slave_address == REG_CTRL);
    assign w_k_ext      = {{(32-COUNT_W){1'b0}}, r_k};
    assign w_rd_addr    = r_src + (w_k_ext * STRIDE) + {24'd0, r_sq, 2'b00};
    assign w_wr_addr    = r_dst + {w_k_ext[29:0], 2'b00};
    assign w_score      = r_colour ? -r_acc : r_acc;
    assign w_better     = w_score > r_best_score;
    assign w_last_board = (r_count == '0) || (r_k == r_count - COUNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Master strobes decode straight from the state register so an async reset
    // removes them in the same cycle.
    always_comb begin
        w_next           = r_state;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_next = (r_count == '0) ? S_NEXT : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                master_read    = 1'b1;
                master_address = w_rd_addr;
                if (!master_waitrequest) begin
                    w_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (master_readdatavalid) begin
                    w_next = S_ACC;
                end
            end
            S_ACC: begin
                w_next = (r_sq == LAST_SQ) ? S_WR_REQ : S_RD_REQ;
            end
            S_WR_REQ: begin
                master_write     = 1'b1;
                master_address   = w_wr_addr;
                master_writedata = w_score;
                if (!master_waitrequest) begin
                    w_next = S_NEXT;
                end
            end
            S_NEXT: begin
                w_next = w_last_board ? S_DONE : S_RD_REQ;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src        <= '0;
            r_dst        <= '0;
            r_count      <= '0;
            r_colour     <= 1'b0;
            r_done       <= 1'b0;
            r_k          <= '0;
            r_sq         <= '0;
            r_code       <= '0;
            r_acc        <= '0;
            r_best_idx   <= BEST_IDX_RST;
            r_best_score <= BEST_SCORE_RST;
        end else begin
            if (w_cfg_we) begin
                case (slave_address)
                    REG_SRC:    r_src    <= slave_writedata;
                    REG_DST:    r_dst    <= slave_writedata;
                    REG_COUNT:  r_count  <= slave_writedata[COUNT_W-1:0];
                    REG_COLOUR: r_colour <= slave_writedata[0];
                    default: ;
                endcase
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_acc        <= '0;
                        r_k          <= '0;
                        r_sq         <= '0;
                        r_done       <= 1'b0;
                        r_best_idx   <= BEST_IDX_RST;
                        r_best_score <= BEST_SCORE_RST;
                    end
                end
                S_RD_WAIT: begin
                    if (master_readdatavalid) begin
                        r_code <= master_readdata[7:0];
                    end
                end
                S_ACC: begin
                    r_acc <= r_acc + w_value;
                    if (r_sq != LAST_SQ) begin
                        r_sq <= r_sq + 6'd1;
                    end
                end
                S_WR_REQ: begin
                    // Strict compare: on a tie the earlier board keeps the title.
                    if (!master_waitrequest && w_better) begin
                        r_best_idx   <= w_k_ext;
                        r_best_score <= w_score;
                    end
                end
                S_NEXT: begin
                    if (w_last_board) begin
                        r_done <= 1'b1;
                    end else begin
                        r_k   <= r_k + COUNT_W'(1);
                        r_sq  <= '0;
                        r_acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign slave_waitrequest = slave_read && (slave_address == REG_CTRL) && w_busy;

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                REG_CTRL:       slave_readdata = {31'd0, r_done};
                REG_SRC:        slave_readdata = r_src;
                REG_DST:        slave_readdata = r_dst;
                REG_COUNT:      slave_readdata = {{(32-COUNT_W){1'b0}}, r_count};
                REG_COLOUR:     slave_readdata = {31'd0, r_colour};
                REG_BEST_IDX:   slave_readdata = r_best_idx;
                REG_BEST_SCORE: slave_readdata = r_best_score;
                default:        slave_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_board_eval.sv
// Directed bench for board_eval: an SDRAM responder with optional stalls checks
// every master transfer against a material-count model built from memory contents.
module tb_board_eval;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;

    board_eval #(.COUNT_W(8), .BOARD_STRIDE(256)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] log_wa[$];
    logic [31:0] log_wd[$];
    int n_chk = 0;
    int n_err = 0;
    int n_reads = 0;
    int n_writes = 0;
    int wait_n = 0;
    int rdv_n = 0;
    int m_best;
    logic [31:0] m_best_idx;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Material value of one square code, straight from the piece table.
    function automatic int piece_val(input int code);
        int m, v;
        m = (code < 0) ? -code : code;
        v = 0;
        if (m >= 1 && m <= 8)        v = 100;
        else if (m >= 9 && m <= 18)  v = 500;
        else if (m >= 19 && m <= 28) v = 320;
        else if (m >= 29 && m <= 38) v = 330;
        else if (m >= 39 && m <= 47) v = 900;
        else if (m == 48)            v = 20000;
        return (code < 0) ? -v : v;
    endfunction

    function automatic int board_score(input logic [31:0] base, input bit colour);
        int s;
        logic [31:0] w;
        logic [31:0] a;
        s = 0;
        for (int sq = 0; sq < 64; sq++) begin
            a = base + 32'(4 * sq);
            w = mem[a[13:2]];
            s += piece_val(int'($signed(w[7:0])));
        end
        return colour ? -s : s;
    endfunction

    task automatic set_sq(input logic [31:0] base, input int sq, input int code);
        logic [31:0] r;
        logic [31:0] a;
        logic [7:0]  c;
        r = $urandom();
        c = 8'(code);
        a = base + 32'(4 * sq);
        mem[a[13:2]] = {r[31:8], c};
    endtask

    task automatic clear_board(input logic [31:0] base);
        for (int sq = 0; sq < 64; sq++) set_sq(base, sq, 0);
    endtask

    // SDRAM responder: stalls each request wait_n cycles, returns data rdv_n cycles late.
    logic [31:0] cap_addr;
    logic        cap_rd, cap_wr;
    int          stall_cnt = 0;
    bit          rd_pending = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_data;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            master_waitrequest   = 1'b0;
            master_readdatavalid = 1'b0;
            master_readdata      = '0;
            rd_pending           = 0;
            stall_cnt            = 0;
        end else begin
            master_readdatavalid = 1'b0;
            if (rd_pending) begin
                if (rd_cnt == 0) begin
                    master_readdatavalid = 1'b1;
                    master_readdata      = rd_data;
                    rd_pending           = 0;
                end else begin
                    rd_cnt--;
                end
            end
            if (master_read || master_write) begin
                if (stall_cnt > 0) begin
                    check("stall_addr_stable", master_address, cap_addr);
                    check("stall_strobe_stable", {30'd0, master_read, master_write}, {30'd0, cap_rd, cap_wr});
                end else begin
                    cap_addr = master_address;
                    cap_rd   = master_read;
                    cap_wr   = master_write;
                end
                if (stall_cnt < wait_n) begin
                    master_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    master_waitrequest = 1'b0;
                    stall_cnt = 0;
                    if (master_read) begin
                        check("one_outstanding", {31'd0, rd_pending}, 32'd0);
                        check("rd_addr", master_address, (exp_rd.size() > 0) ? exp_rd.pop_front() : 'x);
                        rd_data    = mem[master_address[13:2]];
                        rd_pending = 1;
                        rd_cnt     = rdv_n;
                        n_reads++;
                    end else begin
                        check("wr_addr", master_address, (exp_wa.size() > 0) ? exp_wa.pop_front() : 'x);
                        check("wr_data", master_writedata, (exp_wd.size() > 0) ? exp_wd.pop_front() : 'x);
                        log_wa.push_back(master_address);
                        log_wd.push_back(master_writedata);
                        n_writes++;
                    end
                end
            end else begin
                master_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] d, output int stalls);
        @(negedge clk);
        slave_address = a;
        slave_read    = 1'b1;
        stalls        = 0;
        #1;
        while (slave_waitrequest && stalls < 20000) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        check("reg_read_timeout", {31'd0, slave_waitrequest}, 32'd0);
        d = slave_readdata;
        @(posedge clk);
        #1;
        slave_read = 1'b0;
    endtask

    task automatic run_eval(input logic [31:0] src, input logic [31:0] dst, input int count, input bit colour);
        logic [31:0] d;
        int st, s, r0, w0;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        log_wa.delete(); log_wd.delete();
        m_best     = $signed(32'h8000_0000);
        m_best_idx = 32'hFFFF_FFFF;
        for (int k = 0; k < count; k++) begin
            s = board_score(src + 32'(k * 256), colour);
            for (int sq = 0; sq < 64; sq++) exp_rd.push_back(src + 32'(k * 256 + 4 * sq));
            exp_wa.push_back(dst + 32'(4 * k));
            exp_wd.push_back(s);
            if (s > m_best) begin
                m_best     = s;
                m_best_idx = 32'(k);
            end
        end
        reg_write(4'd1, src);
        reg_write(4'd2, dst);
        reg_write(4'd3, 32'(count));
        reg_write(4'd4, {31'd0, colour});
        r0 = n_reads;
        w0 = n_writes;
        reg_write(4'd0, 32'd1);
        if (count > 0) reg_write(4'd1, 32'hDEAD_0000);
        reg_read(4'd0, d, st);
        check("reg0_done", d, 32'd1);
        if (count > 0) check("reg0_stalled", 32'(st > 0), 32'd1);
        else check("cnt0_done_latency", 32'(st <= 2), 32'd1);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        check("wr_queue_drained", 32'(exp_wa.size()), 32'd0);
        check("n_reads", 32'(n_reads - r0), 32'(64 * count));
        check("n_writes", 32'(n_writes - w0), 32'(count));
        reg_read(4'd1, d, st);
        check("src_kept_while_busy", d, src);
        reg_read(4'd5, d, st);
        check("best_idx", d, m_best_idx);
        reg_read(4'd6, d, st);
        check("best_score", d, m_best);
    endtask

    localparam logic [31:0] SRC_OPEN = 32'h0000_0000;
    localparam logic [31:0] SRC_QN   = 32'h0000_0400;
    localparam logic [31:0] SRC_TRI  = 32'h0000_0800;
    localparam logic [31:0] SRC_ODD  = 32'h0000_0C00;

    initial begin
        logic [31:0] d;
        int st, w0;
        bit found;

        #2;
        check("rst_master_read", {31'd0, master_read}, 32'd0);
        check("rst_master_write", {31'd0, master_write}, 32'd0);
        check("rst_master_address", master_address, 32'd0);
        check("rst_master_writedata", master_writedata, 32'd0);
        #20 rst_n = 1'b1;
        reg_read(4'd0, d, st);
        check("rst_reg0", d, 32'd0);
        reg_read(4'd5, d, st);
        check("rst_best_idx", d, 32'hFFFF_FFFF);
        reg_read(4'd6, d, st);
        check("rst_best_score", d, 32'h8000_0000);
        reg_read(4'd9, d, st);
        check("unmapped_read", d, 32'd0);

        // Opening position: white on squares 0-15, black mirrored on 48-63.
        clear_board(SRC_OPEN);
        for (int i = 0; i < 8; i++) begin
            set_sq(SRC_OPEN, 8 + i, 1 + i);
            set_sq(SRC_OPEN, 48 + i, -(1 + i));
        end
        set_sq(SRC_OPEN, 0, 9);  set_sq(SRC_OPEN, 1, 19); set_sq(SRC_OPEN, 2, 29); set_sq(SRC_OPEN, 3, 39);
        set_sq(SRC_OPEN, 4, 48); set_sq(SRC_OPEN, 5, 30); set_sq(SRC_OPEN, 6, 20); set_sq(SRC_OPEN, 7, 10);
        set_sq(SRC_OPEN, 56, -9);  set_sq(SRC_OPEN, 57, -19); set_sq(SRC_OPEN, 58, -29); set_sq(SRC_OPEN, 59, -39);
        set_sq(SRC_OPEN, 60, -48); set_sq(SRC_OPEN, 61, -30); set_sq(SRC_OPEN, 62, -20); set_sq(SRC_OPEN, 63, -10);
        run_eval(SRC_OPEN, 32'h0000_3000, 1, 1'b0);
        check("open_wr_addr", log_wa[0], 32'h0000_3000);
        check("open_score", log_wd[0], 32'd0);
        check("open_model_idx", m_best_idx, 32'd0);

        clear_board(SRC_QN);
        set_sq(SRC_QN, 3, 39);
        set_sq(SRC_QN, 57, -19);
        run_eval(SRC_QN, 32'h0000_3040, 1, 1'b0);
        check("qn_white", log_wd[0], 32'd580);
        run_eval(SRC_QN, 32'h0000_3040, 1, 1'b1);
        check("qn_black", log_wd[0], 32'hFFFF_FDBC);

        clear_board(SRC_TRI);
        clear_board(SRC_TRI + 32'h100);
        clear_board(SRC_TRI + 32'h200);
        set_sq(SRC_TRI, 8, 1);
        set_sq(SRC_TRI + 32'h100, 2, 29);
        set_sq(SRC_TRI + 32'h200, 60, 38);
        run_eval(SRC_TRI, 32'h0000_3000, 3, 1'b0);
        check("tri_addr2", log_wa[2], 32'h0000_3008);
        check("tri_s0", log_wd[0], 32'd100);
        check("tri_s1", log_wd[1], 32'd330);
        check("tri_s2", log_wd[2], 32'd330);
        check("tri_model_idx", m_best_idx, 32'd1);

        // Out-of-table codes (-128, 49, 127, -49) next to range boundaries.
        clear_board(SRC_ODD);
        set_sq(SRC_ODD, 0, -128); set_sq(SRC_ODD, 1, 49);  set_sq(SRC_ODD, 40, 127); set_sq(SRC_ODD, 41, -49);
        set_sq(SRC_ODD, 5, 8);    set_sq(SRC_ODD, 10, 47); set_sq(SRC_ODD, 20, -48); set_sq(SRC_ODD, 30, -9);
        set_sq(SRC_ODD, 62, 28);  set_sq(SRC_ODD, 63, 18);
        run_eval(SRC_ODD, 32'h0000_3080, 1, 1'b0);
        check("odd_score", log_wd[0], 32'hFFFF_B708);

        run_eval(SRC_TRI, 32'h0000_3100, 0, 1'b0);
        check("cnt0_best_idx_lit", m_best_idx, 32'hFFFF_FFFF);

        wait_n = 3;
        rdv_n  = 2;
        run_eval(SRC_TRI, 32'h0000_3100, 3, 1'b0);
        check("stall_addr0", log_wa[0], 32'h0000_3100);
        check("stall_s1", log_wd[1], 32'd330);
        check("stall_s2", log_wd[2], 32'd330);

        // Reset while the second board is being read.
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int sq = 0; sq < 64; sq++) exp_rd.push_back(SRC_TRI + 32'(4 * sq));
        exp_wa.push_back(32'h0000_3200);
        exp_wd.push_back(32'd100);
        for (int sq = 0; sq < 64; sq++) exp_rd.push_back(SRC_TRI + 32'h100 + 32'(4 * sq));
        reg_write(4'd1, SRC_TRI);
        reg_write(4'd2, 32'h0000_3200);
        reg_write(4'd3, 32'd3);
        reg_write(4'd4, 32'd0);
        w0 = n_writes;
        reg_write(4'd0, 32'd1);
        found = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            #1;
            if (master_read && master_address >= SRC_TRI + 32'h100) begin
                found = 1;
                break;
            end
        end
        check("rst_run_reached_board1", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_read", {31'd0, master_read}, 32'd0);
        check("async_rst_write", {31'd0, master_write}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        repeat (300) @(negedge clk);
        check("rst_writes_before_only", 32'(n_writes - w0), 32'd1);
        reg_read(4'd0, d, st);
        check("rst_mid_reg0", d, 32'd0);
        check("rst_mid_reg0_nostall", 32'(st), 32'd0);
        reg_read(4'd5, d, st);
        check("rst_mid_best_idx", d, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
